// File: rtl/apb_regs_pkg.sv
// Shared constants for the APB register block: byte offsets, CTRL field positions, reset values, bus FSM states.
package apb_regs_pkg;

  localparam logic [4:0] CTRL_OFF    = 5'h00;
  localparam logic [4:0] STATUS_OFF  = 5'h04;
  localparam logic [4:0] COMPARE_OFF = 5'h08;
  localparam logic [4:0] COUNT_OFF   = 5'h0C;
  localparam logic [4:0] SCRATCH_OFF = 5'h10;

  localparam int CTRL_TMR_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;
  localparam int STATUS_OVF   = 0;

  localparam logic [31:0] CTRL_MASK   = 32'h0000_FF03;
  localparam logic [31:0] CTRL_RST    = 32'h0000_0000;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] COUNT_RST   = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

endpackage

// File: rtl/apb_regs_timer.sv
// Prescaled up-counter with compare/wrap; ovf_set pulses combinationally on the edge the count wraps.
// COUNT and the prescaler freeze while tmr_en is low; pre_clr restarts the prescaler.
module apb_regs_timer
  import apb_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tmr_en,
  input  logic [7:0]  prescale,
  input  logic        pre_clr,
  input  logic [31:0] compare,
  output logic [31:0] count,
  output logic        ovf_set
);

  logic [7:0] pre_cnt;
  logic       tick;

  assign tick    = tmr_en && (pre_cnt == prescale);
  assign ovf_set = tick && (count == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= COUNT_RST;
    end else begin
      if (pre_clr || tick) pre_cnt <= '0;
      else if (tmr_en)     pre_cnt <= pre_cnt + 8'd1;
      if (ovf_set)   count <= '0;
      else if (tick) count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/apb_regs_slave.sv
// APB register slave (CTRL/STATUS/COMPARE/COUNT/SCRATCH); read data captured entering ACCESS, writes commit on ACCESS exit.
// No wait states: one transfer per two cycles. Timer, COMPARE, COUNT, ovf and irq exist only with APB_REGS_TIMER_EN.
module apb_regs_slave
  import apb_regs_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] SCRATCH_RST = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              irq
);

`ifdef APB_REGS_TIMER_EN
  localparam logic [31:0] CTRL_WMASK = CTRL_MASK;
`else
  localparam logic [31:0] CTRL_WMASK = CTRL_MASK & ~(32'h1 << CTRL_TMR_EN);
`endif

  apb_state_e  state, state_nxt;
  logic        acc_go;
  logic [2:0]  addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        wr_ctrl, wr_scratch;
  logic [31:0] ctrl, scratch;
  logic [31:0] status_rd, compare_rd, count_rd, rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{paddr[ADDR_W-1:5], paddr[1:0]};

  always_comb begin
    state_nxt = state;
    acc_go    = 1'b0;
    case (state)
      IDLE:    if (psel && !penable) state_nxt = SETUP;
      SETUP:   if (!psel) state_nxt = IDLE;
               else if (penable) begin
                 state_nxt = ACCESS;
                 acc_go    = 1'b1;
               end
      ACCESS:  state_nxt = (psel && !penable) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write is held in wr_q/wdata_q through ACCESS so a reset there drops it.
  assign wr_ctrl    = wr_q && ({addr_q, 2'b00} == CTRL_OFF);
  assign wr_scratch = wr_q && ({addr_q, 2'b00} == SCRATCH_OFF);

  always_comb begin
    rd_mux = '0;
    case ({addr_q, 2'b00})
      CTRL_OFF:    rd_mux = ctrl;
      STATUS_OFF:  rd_mux = status_rd;
      COMPARE_OFF: rd_mux = compare_rd;
      COUNT_OFF:   rd_mux = count_rd;
      SCRATCH_OFF: rd_mux = scratch;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      prdata  <= '0;
      ctrl    <= CTRL_RST;
      scratch <= SCRATCH_RST;
    end else begin
      state <= state_nxt;
      wr_q  <= acc_go && pwrite;
      if (psel && !penable)  addr_q  <= paddr[4:2];
      if (acc_go)            wdata_q <= pwdata;
      if (acc_go && !pwrite) prdata  <= rd_mux;
      if (wr_ctrl)           ctrl    <= wdata_q & CTRL_WMASK;
      if (wr_scratch)        scratch <= wdata_q;
    end
  end

`ifdef APB_REGS_TIMER_EN
  logic [31:0] compare, count;
  logic        ovf, ovf_set, pre_clr, wr_status, wr_compare;

  assign wr_status  = wr_q && ({addr_q, 2'b00} == STATUS_OFF);
  assign wr_compare = wr_q && ({addr_q, 2'b00} == COMPARE_OFF);
  assign pre_clr    = wr_ctrl &&
                      (wdata_q[CTRL_PRE_MSB:CTRL_PRE_LSB] != ctrl[CTRL_PRE_MSB:CTRL_PRE_LSB]);

  apb_regs_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tmr_en   (ctrl[CTRL_TMR_EN]),
    .prescale (ctrl[CTRL_PRE_MSB:CTRL_PRE_LSB]),
    .pre_clr  (pre_clr),
    .compare  (compare),
    .count    (count),
    .ovf_set  (ovf_set)
  );

  // A wrap on the same edge as a W1C keeps ovf set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= COMPARE_RST;
      ovf     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_compare) compare <= wdata_q;
      if (ovf_set)                             ovf <= 1'b1;
      else if (wr_status && wdata_q[STATUS_OVF]) ovf <= 1'b0;
      irq <= ovf && ctrl[CTRL_IRQ_EN];
    end
  end

  assign status_rd  = {31'b0, ovf};
  assign compare_rd = compare;
  assign count_rd   = count;
`else
  assign status_rd  = '0;
  assign compare_rd = '0;
  assign count_rd   = '0;
  assign irq        = 1'b0;
`endif

endmodule
